// File: rtl/err_inject_gen_pkg.sv
// Shared types and helpers for the error injection generator.
//   mode_e        : injection mode (off, fixed position, random position, random burst)
//   LFSR_TAPS     : Galois feedback taps for the 32-bit right-shift PRNG
//   burst_pattern : unshifted flip pattern of a given length, bit 0 = first flipped bit
package err_gen_pkg;

  typedef enum logic [1:0] {
    MODE_OFF        = 2'd0,
    MODE_FIXED      = 2'd1,
    MODE_RAND_POS   = 2'd2,
    MODE_RAND_BURST = 2'd3
  } mode_e;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // Upper bound on the pattern width; MAX_BURST must not exceed this.
  localparam int unsigned PAT_W = 1024;

  // Contiguous ones for FIXED/RAND_POS. For RAND_BURST the interior bits follow the low 16
  // LFSR bits while both ends are forced so the span is exactly len.
  function automatic logic [PAT_W-1:0] burst_pattern(input mode_e       mode,
                                                     input int unsigned len,
                                                     input logic [31:0] lfsr);
    logic [PAT_W-1:0] pat;
    pat = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      if (i < len) begin
        if (mode == MODE_RAND_BURST) begin
          pat[i] = lfsr[i[3:0]] | (i == 0) | (i == len - 1);
        end else begin
          pat[i] = 1'b1;
        end
      end
    end
    return pat;
  endfunction

endpackage

// File: rtl/err_inject_gen_if.sv
// Beat stream between CRC encoder, error injector and CRC checker.
//   valid_i/ready_o/data_i/checksum_i : upstream beat into the injector
//   valid_o/ready_i/data_o/checksum_o : downstream beat out of the injector
//   mask_o/corrupted_o                : flip mask applied to the outgoing beat
// slave is the injector's view, master is the view of whoever drives and sinks it.
interface err_inject_gen_if #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned CRC_WIDTH  = 32
);
  localparam int unsigned TOTAL = DATA_WIDTH + CRC_WIDTH;

  logic                  valid_i;
  logic                  ready_o;
  logic [DATA_WIDTH-1:0] data_i;
  logic [CRC_WIDTH-1:0]  checksum_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic [CRC_WIDTH-1:0]  checksum_o;
  logic [TOTAL-1:0]      mask_o;
  logic                  corrupted_o;

  modport slave (
    input  valid_i, data_i, checksum_i, ready_i,
    output ready_o, valid_o, data_o, checksum_o, mask_o, corrupted_o
  );

  modport master (
    output valid_i, data_i, checksum_i, ready_i,
    input  ready_o, valid_o, data_o, checksum_o, mask_o, corrupted_o
  );
endinterface

// File: rtl/err_inject_gen_lfsr32.sv
// 32-bit Galois right-shift LFSR used as the injector's deterministic PRNG.
//   clk, rst : clock, asynchronous active-high reset (loads seed)
//   seed     : reset / reload value, must be non-zero
//   load     : synchronous reload of seed, wins over adv
//   adv      : step the sequence by one
//   value    : current state
module lfsr32
  import err_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] seed,
  input  logic        load,
  input  logic        adv,
  output logic [31:0] value
);

  logic [31:0] next;

  assign next = (value >> 1) ^ (value[0] ? LFSR_TAPS : 32'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= seed;
    end else if (load) begin
      value <= seed;
    end else if (adv) begin
      value <= next;
    end
  end

endmodule

// File: rtl/err_inject_gen.sv
// Error injector between CRC encoder and CRC checker. Flips a configurable pattern of bits
// across the concatenated {checksum, data} word, one register stage, valid/ready flow control.
//   clk, rst     : clock, asynchronous active-high reset
//   clear_i      : zero beat/error counters and reseed the PRNG
//   mode_i       : err_gen_pkg::mode_e encoding
//   burst_len_i  : flip length in bits, clamped to MAX_BURST
//   start_pos_i  : first flipped bit in FIXED mode
//   period_i     : inject on one of every period_i+1 accepted beats
//   bus          : beat stream (slave view)
//   err_cnt_o    : saturating count of corrupted beats emitted
module err_inject_gen
  import err_gen_pkg::*;
#(
  parameter int unsigned  DATA_WIDTH = 512,
  parameter int unsigned  CRC_WIDTH  = 32,
  parameter int unsigned  MAX_BURST  = 32,
  parameter logic [31:0]  SEED       = 32'hACE1_2024,
  localparam int unsigned TOTAL      = DATA_WIDTH + CRC_WIDTH,
  localparam int unsigned BL_W       = $clog2(MAX_BURST + 1),
  localparam int unsigned POS_W      = $clog2(TOTAL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic [1:0]       mode_i,
  input  logic [BL_W-1:0]  burst_len_i,
  input  logic [POS_W-1:0] start_pos_i,
  input  logic [15:0]      period_i,
  err_inject_gen_if.slave  bus,
  output logic [31:0]      err_cnt_o
);

  logic             accept;
  logic [31:0]      lfsr;
  logic [15:0]      beat_cnt_q, beat_cnt_d;
  logic [31:0]      err_cnt_q, err_cnt_d;
  mode_e            mode;
  logic [BL_W-1:0]  len;
  logic [15:0]      range;
  logic [31:0]      prod;
  logic [15:0]      start;
  logic [TOTAL-1:0] mask;

  assign bus.ready_o = !bus.valid_o || bus.ready_i;
  assign accept      = bus.valid_i && bus.ready_o;
  assign err_cnt_o   = err_cnt_q;

  lfsr32 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .seed  (SEED),
    .load  (clear_i),
    .adv   (accept),
    .value (lfsr)
  );

  always_comb begin
    mode  = mode_e'(mode_i);
    len   = (burst_len_i > BL_W'(MAX_BURST)) ? BL_W'(MAX_BURST) : burst_len_i;
    range = 16'(TOTAL) - 16'(len) + 16'd1;
    // Scale the top 16 PRNG bits into [0, range) without a divider.
    prod  = {16'd0, lfsr[31:16]} * {16'd0, range};
    start = (mode == MODE_FIXED) ? 16'(start_pos_i) : prod[31:16];
    mask  = '0;
    if ((beat_cnt_q == 16'd0) && (len != '0) && (mode != MODE_OFF)) begin
      // Bits shifted past TOTAL are dropped rather than wrapped.
      mask = TOTAL'(burst_pattern(mode, 32'(len), lfsr)) << start;
    end
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (clear_i) begin
      beat_cnt_d = '0;
      err_cnt_d  = '0;
    end else if (accept) begin
      beat_cnt_d = (beat_cnt_q == period_i) ? 16'd0 : beat_cnt_q + 16'd1;
      if ((|mask) && (err_cnt_q != 32'hFFFF_FFFF)) begin
        err_cnt_d = err_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.valid_o     <= 1'b0;
      bus.data_o      <= '0;
      bus.checksum_o  <= '0;
      bus.mask_o      <= '0;
      bus.corrupted_o <= 1'b0;
    end else if (accept) begin
      bus.valid_o     <= 1'b1;
      bus.data_o      <= bus.data_i ^ mask[DATA_WIDTH-1:0];
      bus.checksum_o  <= bus.checksum_i ^ mask[TOTAL-1:DATA_WIDTH];
      bus.mask_o      <= mask;
      bus.corrupted_o <= |mask;
    end else if (bus.ready_i) begin
      bus.valid_o     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_err_inject_gen.sv
module tb_err_inject_gen;
  import err_gen_pkg::*;

  localparam int unsigned DW  = 512;
  localparam int unsigned CW  = 32;
  localparam int unsigned MB  = 32;
  localparam int unsigned TOT = DW + CW;
  localparam logic [31:0] SEED_V = 32'hACE1_2024;

  typedef struct {
    logic [DW-1:0]  d;
    logic [CW-1:0]  c;
    logic [TOT-1:0] m;
    logic [31:0]    cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear_i = 1'b0;
  logic [1:0]  mode_i = 2'd0;
  logic [5:0]  burst_len_i = '0;
  logic [9:0]  start_pos_i = '0;
  logic [15:0] period_i = '0;
  logic [31:0] err_cnt_o;

  err_inject_gen_if #(.DATA_WIDTH(DW), .CRC_WIDTH(CW)) bus ();

  err_inject_gen #(
    .DATA_WIDTH (DW),
    .CRC_WIDTH  (CW),
    .MAX_BURST  (MB),
    .SEED       (SEED_V)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (clear_i),
    .mode_i      (mode_i),
    .burst_len_i (burst_len_i),
    .start_pos_i (start_pos_i),
    .period_i    (period_i),
    .bus         (bus),
    .err_cnt_o   (err_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  logic [TOT-1:0] obs_m[$];
  logic obs_c[$];

  // Reference model state
  logic [31:0] m_lfsr = SEED_V;
  logic [15:0] m_beat = '0;
  logic [31:0] m_err = '0;

  task automatic chk(input string name, input logic [TOT-1:0] act, input logic [TOT-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat_d(input int i);
    return {16{32'h9E37_79B9 ^ 32'(i)}};
  endfunction

  function automatic logic [TOT-1:0] model_mask();
    logic [TOT-1:0] m;
    logic [TOT-1:0] one;
    logic [31:0] sh;
    int len, st;
    logic b;
    m   = '0;
    one = TOT'(1);
    len = (int'(burst_len_i) > int'(MB)) ? int'(MB) : int'(burst_len_i);
    if (m_beat != 16'd0 || mode_i == 2'd0 || len == 0) return m;
    if (mode_i == 2'd1) st = int'(start_pos_i);
    else st = int'((longint'({48'd0, m_lfsr[31:16]}) * longint'(int'(TOT) - len + 1)) >>> 16);
    for (int i = 0; i < len; i++) begin
      sh = m_lfsr >> (i % 16);
      b  = (mode_i == 2'd3 && i != 0 && i != len - 1) ? sh[0] : 1'b1;
      if (st + i < int'(TOT) && b) m = m | (one << (st + i));
    end
    return m;
  endfunction

  task automatic model_reset();
    m_lfsr = SEED_V;
    m_beat = '0;
    m_err  = '0;
  endtask

  // Called at a falling edge; returns at the falling edge after the beat is accepted.
  task automatic send_exp(input logic [DW-1:0] d, input logic [CW-1:0] c,
                          input logic [TOT-1:0] m);
    exp_t e;
    int k;
    bus.valid_i    = 1'b1;
    bus.data_i     = d;
    bus.checksum_i = c;
    k = 0;
    #1;
    while (!bus.ready_o && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!bus.ready_o) begin
      chk32("accept_timeout", 32'd0, 32'd1);
    end else begin
      if (m != '0 && m_err != 32'hFFFF_FFFF) m_err++;
      e.d = d ^ m[DW-1:0];
      e.c = c ^ m[TOT-1:DW];
      e.m = m;
      e.cnt = m_err;
      exp_q.push_back(e);
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h8020_0003 : 32'd0);
      m_beat = (m_beat == period_i) ? 16'd0 : m_beat + 16'd1;
    end
    @(posedge clk);
    @(negedge clk);
    bus.valid_i = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] c);
    send_exp(d, c, model_mask());
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    model_reset();
  endtask

  // Monitor: check every beat that is handed downstream on the next rising edge.
  always @(negedge clk) begin : mon
    exp_t e;
    #2;
    if (!rst && bus.valid_o && bus.ready_i) begin
      if (exp_q.size() == 0) begin
        chk32("unexpected_beat", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("data_o", TOT'(bus.data_o), TOT'(e.d));
        chk("checksum_o", TOT'(bus.checksum_o), TOT'(e.c));
        chk("mask_o", bus.mask_o, e.m);
        chk32("corrupted_o", 32'(bus.corrupted_o), 32'(|e.m));
        chk32("err_cnt_o", err_cnt_o, e.cnt);
        obs_m.push_back(bus.mask_o);
        obs_c.push_back(bus.corrupted_o);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [TOT-1:0] first_m;
    logic [TOT-1:0] hm;
    logic [TOT-1:0] tmp;
    int s, lo, hi;

    bus.valid_i    = 1'b0;
    bus.data_i     = '0;
    bus.checksum_i = '0;
    bus.ready_i    = 1'b1;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    chk32("rst_valid_o", 32'(bus.valid_o), 32'd0);
    chk32("rst_err_cnt", err_cnt_o, 32'd0);
    chk("rst_data_o", TOT'(bus.data_o), '0);
    chk32("rst_checksum_o", bus.checksum_o, 32'd0);
    chk("rst_mask_o", bus.mask_o, '0);
    chk32("rst_corrupted_o", 32'(bus.corrupted_o), 32'd0);
    chk32("rst_ready_o", 32'(bus.ready_o), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // First RAND_POS beat after power-on, reference for the reset test
    mode_i = 2'd2; burst_len_i = 6'd5; period_i = 16'd0;
    first_m = model_mask();
    send(pat_d(1), 32'hDEAD_BEEF);
    do_clear();

    // FIXED: inside data, straddling, overflowing, clamped, zero length, OFF
    mode_i = 2'd1; start_pos_i = 10'd3; burst_len_i = 6'd4;
    send_exp('0, '0, TOT'(8'h78));
    start_pos_i = 10'd510;
    hm = TOT'(4'hF) << 510;
    send_exp('0, '0, hm);
    start_pos_i = 10'd540; burst_len_i = 6'd8;
    hm = TOT'(4'hF) << 540;
    send_exp('0, '0, hm);
    start_pos_i = 10'd0; burst_len_i = 6'd40;
    send_exp('1, '0, TOT'(32'hFFFF_FFFF));
    burst_len_i = 6'd0;
    send_exp(pat_d(2), 32'h0F0F_0F0F, '0);
    mode_i = 2'd0; burst_len_i = 6'd4;
    send_exp(pat_d(3), 32'h1111_2222, '0);
    do_clear();

    // Period: inject on beats 0, 3, 6 of 9
    period_i = 16'd2; mode_i = 2'd2; burst_len_i = 6'd1;
    s = obs_c.size();
    for (int i = 0; i < 9; i++) send(pat_d(10 + i), 32'(i) * 32'h0101_0101);
    repeat (2) @(negedge clk);
    chk32("period_err_cnt", err_cnt_o, 32'd3);
    chk32("period_beats_seen", 32'(obs_c.size() - s), 32'd9);
    if (obs_c.size() >= s + 9) begin
      for (int i = 0; i < 9; i++) chk32("period_pattern", 32'(obs_c[s + i]), 32'((i % 3) == 0));
    end
    period_i = 16'd0;
    do_clear();

    // Backpressure: hold for three cycles, mask sequence unaffected
    mode_i = 2'd3; burst_len_i = 6'd6;
    bus.ready_i = 1'b0;
    send(pat_d(20), 32'hA5A5_5A5A);
    fork
      send(pat_d(21), 32'h5A5A_A5A5);
      begin
        for (int j = 0; j < 3; j++) begin
          #1;
          chk32("stall_ready_o", 32'(bus.ready_o), 32'd0);
          chk32("stall_valid_o", 32'(bus.valid_o), 32'd1);
          if (exp_q.size() > 0) chk("stall_hold_data", TOT'(bus.data_o), TOT'(exp_q[0].d));
          @(negedge clk);
        end
        bus.ready_i = 1'b1;
      end
    join
    send(pat_d(22), 32'h0000_FFFF);
    @(negedge clk);
    do_clear();

    // Determinism: same 100 RAND_BURST beats twice across a clear
    mode_i = 2'd3; burst_len_i = 6'd8;
    s = obs_m.size();
    for (int i = 0; i < 100; i++) send(pat_d(100 + i), 32'(i));
    do_clear();
    for (int i = 0; i < 100; i++) send(pat_d(100 + i), 32'(i));
    repeat (2) @(negedge clk);
    chk32("determinism_beats", 32'(obs_m.size() - s), 32'd200);
    if (obs_m.size() >= s + 200) begin
      for (int i = 0; i < 100; i++) chk("determinism", obs_m[s + 100 + i], obs_m[s + i]);
      for (int i = 0; i < 200; i++) begin
        lo = -1; hi = -1;
        for (int b = 0; b < int'(TOT); b++) begin
          tmp = obs_m[s + i] >> b;
          if (tmp[0]) begin
            if (lo < 0) lo = b;
            hi = b;
          end
        end
        chk32("burst_span", 32'(hi - lo), 32'd7);
      end
    end
    do_clear();

    // Reset mid-stream with a held beat and err_cnt_o = 5
    mode_i = 2'd1; start_pos_i = 10'd0; burst_len_i = 6'd1;
    for (int i = 0; i < 4; i++) send(pat_d(300 + i), 32'(i));
    @(negedge clk);
    bus.ready_i = 1'b0;
    send(pat_d(304), 32'd4);
    chk32("pre_rst_err_cnt", err_cnt_o, 32'd5);
    chk32("pre_rst_valid_o", 32'(bus.valid_o), 32'd1);
    rst = 1'b1;
    #1;
    chk32("mid_rst_valid_o", 32'(bus.valid_o), 32'd0);
    chk32("mid_rst_err_cnt", err_cnt_o, 32'd0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.ready_i = 1'b1;
    mode_i = 2'd2; burst_len_i = 6'd5;
    send(pat_d(400), 32'hCAFE_F00D);
    #2;
    chk("reset_reseed_mask", bus.mask_o, first_m);

    repeat (3) @(negedge clk);
    chk32("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
